// File: rtl/pcie_rd_req_arbiter.sv
// Round-robin arbiter sharing the PCIe TX read-request port between DMA requesters,
// with per-requester outstanding-beat credit and tag-based completion routing.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARB      | scan requesters from last_grant+1 for an eligible request
// WAIT_ACK | request presented to the TX engine, fields held stable
// RELEASE  | req_ack_o pulse on the wire, requester swaps/drops req_i
module pcie_rd_req_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int MAX_BEATS = 1024
) (
   input  logic                    pcie_clk_i,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_i,
   input  logic [NUM_REQ*12-1:0]   req_len_i,
   input  logic [NUM_REQ*32-1:0]   req_addr_i,
   input  logic [NUM_REQ*6-1:0]    req_tag_i,
   output logic [NUM_REQ-1:0]      req_ack_o,
   output logic                    dma_rd_req_o,
   input  logic                    dma_req_ack_i,
   output logic [11:0]             dma_rd_req_len_o,
   output logic [31:0]             dma_rd_req_addr_o,
   output logic [7:0]              dma_rd_tag_o,
   input  logic [7:0]              dma_tag_i,
   input  logic                    dma_data_valid_i,
   input  logic [63:0]             dma_data_i,
   output logic [NUM_REQ-1:0]      cpl_valid_o,
   output logic [5:0]              cpl_tag_o,
   output logic [63:0]             cpl_data_o,
   output logic [NUM_REQ-1:0]      idle_o,
   output logic                    err_o
);

   typedef enum logic [1:0] {
      ARB      = 2'd0,
      WAIT_ACK = 2'd1,
      RELEASE  = 2'd2
   } state_t;

   state_t       state, state_nxt;
   logic [1:0]   last_grant;

   // Inputs padded to four slots so every index below is in range for any NUM_REQ.
   logic [3:0]   req_pad;
   logic [47:0]  len_pad;
   logic [127:0] addr_pad;
   logic [23:0]  tag_pad;

   logic [11:0]  len_arr   [4];
   logic [31:0]  addr_arr  [4];
   logic [5:0]   tag_arr   [4];
   logic [9:0]   beats_arr [4];
   logic [10:0]  outst     [4];
   logic [10:0]  outst_nxt [4];
   logic [3:0]   elig;

   logic         win;
   logic [1:0]   win_idx;
   logic [2:0]   scan_idx;
   logic         do_grant;
   logic         do_ack;

   logic [1:0]   cpl_id;
   logic         cpl_ok;
   logic         cpl_bad_id;
   logic         cpl_underflow;
   logic [NUM_REQ-1:0] ack_nxt;
   logic [NUM_REQ-1:0] cpl_valid_nxt;

   function automatic logic [9:0] beats(input logic [11:0] len);
      logic [12:0] sum;
      sum = {1'b0, len} + 13'd7;
      if (len == 12'd0) begin
         beats = 10'd512;
      end else begin
         beats = sum[12:3];
      end
   endfunction

   assign req_pad  = 4'(req_i);
   assign len_pad  = 48'(req_len_i);
   assign addr_pad = 128'(req_addr_i);
   assign tag_pad  = 24'(req_tag_i);

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         len_arr[k]   = len_pad[12*k +: 12];
         addr_arr[k]  = addr_pad[32*k +: 32];
         tag_arr[k]   = tag_pad[6*k +: 6];
         beats_arr[k] = beats(len_arr[k]);
         elig[k]      = req_pad[k] &&
                        (({1'b0, outst[k]} + {2'b00, beats_arr[k]}) <= 12'(MAX_BEATS));
      end
   end

   // Round-robin scan starting just after the last acknowledged requester.
   always_comb begin
      win      = 1'b0;
      win_idx  = 2'd0;
      scan_idx = 3'd0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         scan_idx = {1'b0, last_grant} + 3'(i);
         if (scan_idx >= 3'(NUM_REQ)) begin
            scan_idx = scan_idx - 3'(NUM_REQ);
         end
         if (!win && elig[scan_idx[1:0]]) begin
            win     = 1'b1;
            win_idx = scan_idx[1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB:      if (win) state_nxt = WAIT_ACK;
         WAIT_ACK: if (dma_req_ack_i) state_nxt = RELEASE;
         RELEASE:  state_nxt = ARB;
         default:  state_nxt = ARB;
      endcase
   end

   assign do_grant = (state == ARB) && win;
   assign do_ack   = (state == WAIT_ACK) && dma_req_ack_i;

   assign cpl_id        = dma_tag_i[7:6];
   assign cpl_ok        = dma_data_valid_i && ({1'b0, cpl_id} < 3'(NUM_REQ));
   assign cpl_bad_id    = dma_data_valid_i && !cpl_ok;
   assign cpl_underflow = cpl_ok && (outst[cpl_id] == 11'd0);

   // Grant increment and completion decrement can land on the same counter in one cycle.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         outst_nxt[k] = outst[k];
         if (do_grant && (win_idx == 2'(k))) begin
            outst_nxt[k] = outst_nxt[k] + 11'(beats_arr[k]);
         end
         if (cpl_ok && (cpl_id == 2'(k)) && (outst[k] != 11'd0)) begin
            outst_nxt[k] = outst_nxt[k] - 11'd1;
         end
      end
   end

   always_comb begin
      ack_nxt       = '0;
      cpl_valid_nxt = '0;
      idle_o        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         ack_nxt[k]       = do_ack && (dma_rd_tag_o[7:6] == 2'(k));
         cpl_valid_nxt[k] = cpl_ok && (cpl_id == 2'(k));
         idle_o[k]        = (outst[k] == 11'd0);
      end
   end

   always_ff @(posedge pcie_clk_i) begin
      if (!rst_n) begin
         state      <= ARB;
         last_grant <= 2'(NUM_REQ - 1);
      end else begin
         state <= state_nxt;
         if (do_ack) begin
            last_grant <= dma_rd_tag_o[7:6];
         end
      end
   end

   always_ff @(posedge pcie_clk_i) begin
      if (!rst_n) begin
         dma_rd_req_o      <= 1'b0;
         dma_rd_req_len_o  <= '0;
         dma_rd_req_addr_o <= '0;
         dma_rd_tag_o      <= '0;
         req_ack_o         <= '0;
      end else begin
         req_ack_o <= ack_nxt;
         if (do_grant) begin
            dma_rd_req_o      <= 1'b1;
            dma_rd_req_len_o  <= len_arr[win_idx];
            dma_rd_req_addr_o <= addr_arr[win_idx];
            dma_rd_tag_o      <= {win_idx, tag_arr[win_idx]};
         end else if (do_ack) begin
            dma_rd_req_o <= 1'b0;
         end
      end
   end

   always_ff @(posedge pcie_clk_i) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            outst[k] <= '0;
         end
         cpl_valid_o <= '0;
         cpl_tag_o   <= '0;
         cpl_data_o  <= '0;
         err_o       <= 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            outst[k] <= outst_nxt[k];
         end
         cpl_valid_o <= cpl_valid_nxt;
         if (cpl_ok) begin
            cpl_tag_o  <= dma_tag_i[5:0];
            cpl_data_o <= dma_data_i;
         end
         if (cpl_bad_id || cpl_underflow) begin
            err_o <= 1'b1;
         end
      end
   end

endmodule

// File: doc/pcie_rd_req_arbiter.md
Name: pcie_rd_req_arbiter

Overview:
Shares the single PCIe TX-engine read-request port between up to four DMA requesters, e.g. DDR DMA controllers and user stream engines. Each requester has its own local tag space. The block prefixes the local tag with the requester ID, arbitrates round-robin under per-requester outstanding-credit limits, and routes RX completion beats back by tag. It sits between the DMA controllers and the TX/RX engines in the pcie_clk_i domain.

Parameters:
NUM_REQ, 2, number of requesters; legal range 1..4.
MAX_BEATS, 1024, maximum outstanding 64-bit completion beats per requester; legal range 1..2047.

Ports:
pcie_clk_i  in  1  clock
rst_n  in  1  reset
req_i  in  NUM_REQ  per-requester read request; held with fields stable until req_ack_o
req_len_i  in  NUM_REQ*12  byte length per requester, slice k = [12k+11:12k]; 0 means 4096
req_addr_i  in  NUM_REQ*32  byte address per requester, slice k
req_tag_i  in  NUM_REQ*6  local tag per requester, slice k
req_ack_o  out  NUM_REQ  one-cycle acceptance pulse
dma_rd_req_o  out  1  request to TX engine
dma_req_ack_i  in  1  TX engine accepts request
dma_rd_req_len_o  out  12  granted length
dma_rd_req_addr_o  out  32  granted address
dma_rd_tag_o  out  8  {requester ID[1:0], local tag[5:0]}
dma_tag_i  in  8  RX completion tag
dma_data_valid_i  in  1  RX completion beat valid
dma_data_i  in  64  RX completion data
cpl_valid_o  out  NUM_REQ  routed beat valid, one-hot
cpl_tag_o  out  6  local tag of routed beat
cpl_data_o  out  64  routed beat data
idle_o  out  NUM_REQ  requester k has zero outstanding beats
err_o  out  1  sticky: completion underflow or tag ID >= NUM_REQ

Behaviour:
- Reset is synchronous, active-low (rst_n), on pcie_clk_i. Reset values:
  - state ARB; last_grant = NUM_REQ-1, so requester 0 has first priority.
  - dma_rd_req_o=0, req_ack_o=0, cpl_valid_o=0, err_o=0.
  - All outstanding counters 0, so idle_o = all 1.
  - len/addr/tag/cpl_tag/cpl_data outputs = 0.
- Reset mid-operation discards all in-flight state. Completions arriving afterwards count as underflow (err_o=1).
- beats(len): len==0 gives 512, otherwise (len+7)>>3. Width 10 bits.
- Eligibility of requester k: req_i[k]=1 and outst[k]+beats(len_k) <= MAX_BEATS. Compare at 12-bit width, no overflow.
- ARB state:
  - Scan from last_grant+1 upward, modulo NUM_REQ; the first eligible requester g wins.
  - On a win: latch len/addr into the dma_rd_req_* outputs, set tag = {g[1:0], req_tag_i[g]}, set dma_rd_req_o<=1, set outst[g] += beats, go to WAIT_ACK.
  - No eligible requester: stay in ARB.
- WAIT_ACK state:
  - Outputs are held stable.
  - On dma_req_ack_i: dma_rd_req_o<=0, req_ack_o[g]<=1, last_grant<=g, go to RELEASE.
  - dma_req_ack_i sampled in any other state is ignored.
- RELEASE state: req_ack_o<=0, go to ARB. The requester must drop or replace req_i on the edge after seeing req_ack_o.
- Minimum spacing is 3 cycles per grant. Credit is reserved at grant time, before the ack.
- Completion path (registered, 1-cycle latency):
  - On dma_data_valid_i with id = dma_tag_i[7:6] < NUM_REQ: next cycle cpl_valid_o[id]=1, cpl_tag_o=dma_tag_i[5:0], cpl_data_o=dma_data_i.
  - On the same edge, outst[id] -= 1.
  - If id >= NUM_REQ: beat dropped, err_o<=1.
  - If outst[id]==0: counter stays 0 (saturate), beat is still forwarded, err_o<=1.
- Simultaneous grant-increment and completion-decrement on the same requester: net update outst + beats - 1 in one cycle.
- idle_o[k] = (outst[k]==0), combinational from the counter.
- req_i dropped while in WAIT_ACK is illegal. The block still completes the handshake using the latched fields.

Test Plan:
- Single request: reset, then req0 with len=4096 (0), addr=0x1000_0000, tag=5. Required: dma_rd_tag_o=0x05, len=0, ack after 3 cycles, single req_ack_o[0] pulse, idle_o[0]=0. Then 512 beats with tag 0x05 give cpl_valid_o[0]×512 at 1-cycle latency and idle_o[0]=1.
- Round-robin: req0 and req1 held continuously, len=64. Required grant order 0,1,0,1; tags 0x00, 0x40, …; no requester granted twice in a row.
- Credit limit: MAX_BEATS=1024, req0 len=0 issued twice (1024 beats outstanding). A third req0 is not granted while req1 is still granted. After one beat returns, req0 stays blocked (1023+512>1024). After 512 beats return, req0 is granted.
- Routing: interleave beats with tags 0x03 and 0x47. Required: cpl_valid_o toggles between [0] and [1], cpl_tag_o = 3 and 7, data matches input delayed 1 cycle.
- Errors: a beat with tag 0xC0 when NUM_REQ=2 is dropped and sets err_o=1; a beat to requester 0 with outst=0 is forwarded, err_o=1, counter stays 0.
- Reset mid-WAIT_ACK: deassert rst_n one cycle. Required: dma_rd_req_o=0, idle_o all 1, and the next grant goes to requester 0.
